// File: rtl/seq_det_prog.sv
// seq_det_prog: runtime-programmable serial pattern detector.
// Matches a 1..MAX_LEN bit pattern (MSB received first) against a qualified
// serial stream. Detection can overlap or not. The match pulse is registered
// (Moore-style), and a saturating counter tallies the matches.
module seq_det_prog #(
    parameter int                 MAX_LEN       = 8,
    parameter int                 CNT_W         = 8,
    parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(9),
    parameter int                 RESET_LEN     = 4,
    parameter bit                 RESET_OVERLAP = 1'b1,
    localparam int                LEN_W         = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               data_in,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] next_hist;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_p1;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   len_clamped;
    logic               hit;

    // Clamp the requested length into 1..MAX_LEN before it is stored.
    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0)
            len_clamped = LEN_W'(1);
        else if (cfg_len > MAX_LEN_L)
            len_clamped = MAX_LEN_L;
    end

    // Hit detection: enough bits seen, and the last len bits equal the pattern.
    // The window is the history with the incoming bit shifted in, because the
    // match must fire on the edge that accepts the final pattern bit.
    always_comb begin
        next_hist = MAX_LEN'({hist, data_in});
        len_mask  = '0;
        for (int i = 0; i < MAX_LEN; i++)
            len_mask[i] = (LEN_W'(i) < len);
        fill_p1  = {1'b0, fill} + (LEN_W + 1)'(1);
        fill_inc = (fill == MAX_LEN_L) ? fill : fill_p1[LEN_W-1:0];
        hit      = in_valid
                   && (fill_p1 >= {1'b0, len})
                   && (((next_hist ^ pattern) & len_mask) == '0);
    end

    // Config, history, fill, match pulse and counter.
    // Precedence: clear beats cfg_load, which beats in_valid. A simultaneous
    // clear and cfg_load still loads the new config.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern     <= RESET_PATTERN;
            len         <= LEN_W'(RESET_LEN);
            overlap     <= RESET_OVERLAP;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else if (clear) begin
            if (cfg_load) begin
                pattern <= cfg_pattern;
                len     <= len_clamped;
                overlap <= cfg_overlap;
            end
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len     <= len_clamped;
            overlap <= cfg_overlap;
            fill    <= '0;
            match   <= 1'b0;
        end else if (in_valid) begin
            hist <= next_hist;
            if (hit) begin
                match <= 1'b1;
                if (!count_sat)
                    match_count <= match_count + CNT_W'(1);
                // Without overlap, the next match must be built from fresh bits.
                fill <= overlap ? fill_inc : '0;
            end else begin
                match <= 1'b0;
                fill  <= fill_inc;
            end
        end else begin
            match <= 1'b0;
        end
    end

    assign count_sat = (match_count == {CNT_W{1'b1}});

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Runtime-programmable serial pattern detector: the generalised successor of the fixed 4-bit "1001" Moore detectors in the sequential library. It matches a pattern of 1..MAX_LEN bits against a qualified serial bit stream, in overlapping or non-overlapping mode. It produces a registered (Moore-style) one-cycle match pulse and a saturating match counter. It sits between a bit-serial front end (deserialiser or line sampler) and status/interrupt logic.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- RESET_PATTERN, 8'b0000_1001: pattern value after reset (MAX_LEN bits).
- RESET_LEN, 4: pattern length after reset.
- RESET_OVERLAP, 1: overlap mode after reset.
- LEN_W, derived: $clog2(MAX_LEN+1); not overridden.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- clear, in, 1: synchronous clear of history, match and counter.
- cfg_load, in, 1: load cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern, in, MAX_LEN: pattern; bit [len-1] is received first and bit [0] last; bits above len-1 are ignored.
- cfg_len, in, LEN_W: pattern length.
- cfg_overlap, in, 1: 1 = overlapping detection, 0 = non-overlapping.
- in_valid, in, 1: data_in is accepted on this edge.
- data_in, in, 1: serial data bit.
- match, out, 1: registered match pulse.
- match_count, out, CNT_W: number of matches, saturating.
- count_sat, out, 1: match_count is all ones.

## Operation
- **Config registers** (pattern, len, overlap):
  - Reset to the RESET_* values.
  - Loaded on cfg_load.
  - Length clamping at load: len 0 → 1; len > MAX_LEN → MAX_LEN.
- **History shift register** hist[MAX_LEN-1:0]:
  - On an accepted bit: hist <= {hist[MAX_LEN-2:0], data_in}.
- **Fill counter** (0..MAX_LEN):
  - Counts bits accepted since reset, clear, cfg_load or (non-overlap mode) the last match.
  - Saturates at MAX_LEN.
- **Hit condition** (combinational on an accepted bit):
  - fill+1 ≥ len, and
  - the last len bits, i.e. {hist, data_in}[len-1:0], equal pattern[len-1:0].
- **On a hit:**
  - match <= 1 and match_count increments (holds once all ones).
  - Overlap mode: fill continues counting, so a suffix of a match can start the next one.
  - Non-overlap mode: fill <= 0, so the next match needs len fresh bits.
- **Otherwise:** match <= 0.
- **Input gaps:** in_valid = 0 freezes hist and fill; match <= 0.
- **cfg_load:**
  - Loads config; fill <= 0; match <= 0.
  - match_count is retained.
  - The data_in bit presented in the same cycle is dropped.
- **clear:** fill <= 0, match <= 0, match_count <= 0; the data bit in the same cycle is dropped.
- **Precedence:** reset_n > clear > cfg_load > in_valid. When clear and cfg_load are both high, the config is still loaded.
- **count_sat** is combinational from match_count == {CNT_W{1'b1}}.

## Timing
- **Reset values:** match = 0, match_count = 0, count_sat = 0, hist = 0, fill = 0; config = RESET_* values.
- **Latency:** match rises on the clock edge that accepts the final pattern bit.
  - It is visible for exactly the following cycle.
  - One pulse per hit; back-to-back hits give consecutive high cycles.
- match_count updates on the same edge as match.
- New config is effective for the first bit accepted after the loading edge.
- **len = 1:** every accepted bit equal to pattern[0] is a hit, in either mode.
- **Reset mid-pattern:** partial history is discarded immediately (asynchronously); the first match needs len bits after reset_n deasserts.

## Test plan
- **Default config, overlap:** after reset, stream 1,0,0,1,0,0,1 with in_valid = 1 → match high in the cycles after bits 4 and 7; match_count = 2.
- **Non-overlap:** cfg_overlap = 0, pattern 1001, len 4; stream 1001001 → single match after bit 4; match_count = 1.
- **Valid gaps and reprogramming:**
  - 1001 with in_valid low for 3 cycles between each bit → exactly one match after the 4th valid bit.
  - Then cfg_load pattern 3'b110, len 3; stream 1,1,0,1,1,0 → matches after bits 3 and 6; the bit sent with cfg_load is ignored.
- **Clamping and len 1:**
  - cfg_len = 0, pattern[0] = 1; stream 1,0,1,1 → three matches.
  - cfg_len = 15 with MAX_LEN = 8 → behaves as len 8; 8'hA5 is detected only after 8 bits.
- **Saturation:** CNT_W = 4, 20 overlapping hits → match_count stops at 15; count_sat = 1; match still pulses. Then clear → count 0; count_sat = 0.
- **Reset and clear mid-stream:**
  - Assert reset_n low after bits 1,0,0, then send 1 → no match.
  - Assert clear after 1,0,0, then send 1 → no match.
  - In both cases, a full 1001 afterwards → match.
